input_mod: RTL and testbench

Processor input peripheral: serves the IN instruction by stalling the core until the operator sets the board switches and presses a confirm key. The raw switch and key signals are synchronized and the key is debounced. On a confirmed press, the block captures the switch value, extends it to the data-path width and returns it to the register file with a one-cycle valid pulse. It is the input-side counterpart of the display output module and sits on the same I/O decode.

---
 rtl/input_mod.sv | 154 +++++++++++++++
 tb/tb_input_mod.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/input_mod.sv
// ----------------------------------------------------------------------------
// input_mod -- input peripheral that serves the IN instruction.
//
// When the control unit raises read_req, the block stalls the core and waits
// for the operator to press the confirm key. The block then latches the
// switch bank, extends it to 32 bits and returns it with a one-cycle valid
// pulse. The raw switches and key pass through 2-flop synchronizers, and the
// key is debounced before any edge on it is used.
//
// Parameters
//   SW_W      switch bank width (1..32)
//   DEBOUNCE  consecutive stable cycles needed to accept a key level change
//   SIGN_EXT  1 = sign-extend the switch value, 0 = zero-extend
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   switches  raw board switches (asynchronous)
//   key_n     raw confirm pushbutton, active-low, bouncing
//   read_req  level request, held high for the whole IN instruction
//   data_out  captured, extended switch value (holds the last capture)
//   valid     one-cycle pulse: data_out is new this cycle
//   stall     freeze PC/pipeline while high
//   waiting   "enter value" LED, high while waiting for the key
// ----------------------------------------------------------------------------
module input_mod #(
    parameter int SW_W     = 16,
    parameter int DEBOUNCE = 500000,
    parameter int SIGN_EXT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] switches,
    input  logic            key_n,
    input  logic            read_req,
    output logic [31:0]     data_out,
    output logic            valid,
    output logic            stall,
    output logic            waiting
);

    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // ---------------- synchronizers ----------------
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;
    logic            key_s1_q, key_s2_q;

    // key sync resets to 1 so that a reset never looks like a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
        end else begin
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
        end
    end

    // ---------------- debouncer ----------------
    logic             pressed_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_db_q, key_db_d;
    logic             key_db_prev_q;
    logic             press_evt;

    assign pressed_s = ~key_s2_q;

    // The counter tracks how long the synchronized level has disagreed with
    // key_db. Any agreement clears it, so only an unbroken run of DEBOUNCE
    // mismatching cycles flips key_db.
    always_comb begin
        cnt_d    = '0;
        key_db_d = key_db_q;
        if (pressed_s != key_db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                key_db_d = ~key_db_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            key_db_q      <= 1'b0;
            key_db_prev_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
        end
    end

    // Edge-only: a key already held when WAIT is entered never fires.
    assign press_evt = key_db_q & ~key_db_prev_q;

    // ---------------- FSM ----------------
    logic [1:0] state_q, state_d;
    logic       capture;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (read_req) state_d = S_WAIT;
            // abort takes priority over a coincident press
            S_WAIT: begin
                if (!read_req)      state_d = S_IDLE;
                else if (press_evt) state_d = S_DONE;
            end
            S_DONE: state_d = S_HOLD;
            S_HOLD: if (!read_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign capture = (state_q == S_WAIT) && (state_d == S_DONE);

    // ---------------- capture / extension ----------------
    logic [31:0] sw_ext;
    logic [31:0] data_q;

    always_comb begin
        sw_ext = (SIGN_EXT != 0) ? {32{sw_s2_q[SW_W-1]}} : 32'd0;
        sw_ext[SW_W-1:0] = sw_s2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) data_q <= sw_ext;
        end
    end

    // stall follows read_req combinationally in IDLE so the IN instruction
    // cannot advance in the cycle before WAIT is entered
    assign data_out = data_q;
    assign valid    = (state_q == S_DONE);
    assign waiting  = (state_q == S_WAIT);
    assign stall    = (state_q == S_WAIT) || ((state_q == S_IDLE) && read_req);

endmodule

// File: tb/tb_input_mod.sv
module tb_input_mod;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] switches;
    logic        key_n;
    logic        read_req;
    logic [31:0] data_out, data_out_sx;
    logic        valid, stall, waiting;
    logic        valid_sx, stall_sx, waiting_sx;

    int n_chk  = 0;
    int n_pass = 0;
    int vcnt   = 0;

    always #5 clk = ~clk;

    input_mod #(.SW_W(16), .DEBOUNCE(4), .SIGN_EXT(0)) dut (
        .clk(clk), .reset(reset), .switches(switches), .key_n(key_n),
        .read_req(read_req), .data_out(data_out), .valid(valid),
        .stall(stall), .waiting(waiting)
    );

    input_mod #(.SW_W(16), .DEBOUNCE(4), .SIGN_EXT(1)) dut_sx (
        .clk(clk), .reset(reset), .switches(switches), .key_n(key_n),
        .read_req(read_req), .data_out(data_out_sx), .valid(valid_sx),
        .stall(stall_sx), .waiting(waiting_sx)
    );

    // valid pulses of the zero-extend instance, sampled in the cycle they are high
    always @(posedge clk) if (valid) vcnt <= vcnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ticks until valid is seen; n = edges taken, -1 if the bound expired
    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < max);
        if (!valid) n = -1;
    endtask

    int n, v0;

    initial begin
        reset = 1'b0; switches = '0; key_n = 1'b1; read_req = 1'b0;
        tick(2);
        chk("rst_data", data_out, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wait", {31'd0, waiting}, 32'd0);
        reset = 1'b1;
        tick(2);

        // ---- basic read ----
        switches = 16'h00A5; read_req = 1'b1; #1;
        chk("idle_stall_comb", {31'd0, stall}, 32'd1);
        chk("idle_wait", {31'd0, waiting}, 32'd0);
        tick();
        chk("wait_state", {31'd0, waiting}, 32'd1);
        v0 = vcnt;
        key_n = 1'b0;
        wait_valid(20, n);
        chk("basic_latency", n, 7);
        chk("basic_data", data_out, 32'h0000_00A5);
        chk("basic_data_sx", data_out_sx, 32'h0000_00A5);
        chk("done_stall", {31'd0, stall}, 32'd0);
        switches = 16'hFFFF;  // post-capture change must not matter
        tick();
        chk("hold_valid", {31'd0, valid}, 32'd0);
        chk("hold_stall", {31'd0, stall}, 32'd0);
        key_n = 1'b1; tick(6);
        chk("basic_one_valid", vcnt - v0, 1);
        chk("hold_data", data_out, 32'h0000_00A5);
        read_req = 1'b0; tick(2);

        // ---- sign extension ----
        switches = 16'h8001; read_req = 1'b1; tick();
        key_n = 1'b0;
        wait_valid(20, n);
        chk("sx_latency", n, 7);
        chk("zx_data", data_out, 32'h0000_8001);
        chk("sx_data", data_out_sx, 32'hFFFF_8001);
        key_n = 1'b1; read_req = 1'b0; tick(8);

        // ---- bounce rejection, then a settled press ----
        switches = 16'h1234; read_req = 1'b1; tick();
        v0 = vcnt;
        key_n = 1'b0; tick(1); key_n = 1'b1; tick(2);
        key_n = 1'b0; tick(2); key_n = 1'b1; tick(1);
        key_n = 1'b0; tick(3); key_n = 1'b1; tick(2);
        chk("bounce_no_valid", vcnt - v0, 0);
        chk("bounce_stall", {31'd0, stall}, 32'd1);
        key_n = 1'b0;
        wait_valid(20, n);
        chk("bounce_latency", n, 7);
        chk("bounce_data", data_out, 32'h0000_1234);
        key_n = 1'b1; tick(6);
        chk("bounce_one_valid", vcnt - v0, 1);
        read_req = 1'b0; tick(2);

        // ---- glitches only, then abort ----
        switches = 16'h7777; read_req = 1'b1; tick();
        v0 = vcnt;
        key_n = 1'b0; tick(3); key_n = 1'b1; tick(2);
        key_n = 1'b0; tick(2); key_n = 1'b1; tick(8);
        chk("glitch_no_valid", vcnt - v0, 0);
        chk("glitch_stall", {31'd0, stall}, 32'd1);
        chk("glitch_wait", {31'd0, waiting}, 32'd1);
        read_req = 1'b0; tick();
        chk("abort_wait", {31'd0, waiting}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_data", data_out, 32'h0000_1234);
        chk("abort_no_valid", vcnt - v0, 0);

        // ---- held key ----
        key_n = 1'b0; tick(8);
        read_req = 1'b1; v0 = vcnt; tick(10);
        chk("held_no_valid", vcnt - v0, 0);
        chk("held_wait", {31'd0, waiting}, 32'd1);
        key_n = 1'b1; tick(8);
        switches = 16'h0F0F; key_n = 1'b0;
        wait_valid(20, n);
        chk("held_latency", n, 7);
        chk("held_data", data_out, 32'h0000_0F0F);
        key_n = 1'b1; tick(6);

        // ---- back-to-back reads, one low cycle apart ----
        v0 = vcnt;
        read_req = 1'b0; tick();
        read_req = 1'b1; switches = 16'h5555; tick();
        chk("b2b_wait1", {31'd0, waiting}, 32'd1);
        key_n = 1'b0; wait_valid(20, n);
        chk("b2b_data1", data_out, 32'h0000_5555);
        key_n = 1'b1; tick(6);
        read_req = 1'b0; tick();
        read_req = 1'b1; switches = 16'hAAAA; tick();
        chk("b2b_wait2", {31'd0, waiting}, 32'd1);
        key_n = 1'b0; wait_valid(20, n);
        chk("b2b_data2", data_out, 32'h0000_AAAA);
        chk("b2b_data2_sx", data_out_sx, 32'hFFFF_AAAA);
        key_n = 1'b1; tick(6);
        chk("b2b_two_valid", vcnt - v0, 2);

        // ---- press event coincident with abort ----
        read_req = 1'b0; tick();
        read_req = 1'b1; switches = 16'h3C3C; tick();
        v0 = vcnt;
        key_n = 1'b0; tick(6);   // press_evt is high in this cycle
        read_req = 1'b0; tick();
        chk("race_valid", {31'd0, valid}, 32'd0);
        chk("race_state", {31'd0, waiting}, 32'd0);
        tick(3);
        chk("race_no_valid", vcnt - v0, 0);
        chk("race_data", data_out, 32'h0000_AAAA);
        key_n = 1'b1; tick(8);

        // ---- async reset mid-WAIT ----
        read_req = 1'b1; tick();
        #2 reset = 1'b0; read_req = 1'b0; #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_wait", {31'd0, waiting}, 32'd0);
        chk("arst_data", data_out, 32'h0);
        tick(2);
        reset = 1'b1; v0 = vcnt;
        key_n = 1'b0; tick(15);
        chk("arst_no_valid", vcnt - v0, 0);
        chk("arst_data_after", data_out, 32'h0);
        key_n = 1'b1; tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
